// File: rtl/timer_pkg.sv
// Shared definitions for pulse_stretch: FSM state encodings and the
// saturation limit of the request queue.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam logic [2:0] PEND_MAX = 3'd7;

endpackage

// File: rtl/pulse_stretch.sv
// Stretches single-cycle trig events into HIGH_CYC-long pulses separated by at
// least GAP_CYC low cycles. Define PULSE_QUEUE_EN to queue (up to 7) requests
// that arrive while a pulse or its gap is running.
module pulse_stretch
  import timer_pkg::*;
#(
  parameter int unsigned N        = 22,
  parameter int unsigned HIGH_CYC = 4_000_000,
  parameter int unsigned GAP_CYC  = 4_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig,
  output logic       out_level,
  output logic       out_start,
  output logic       busy,
  output logic [2:0] pending
);

  // Counters run from LOAD down to 0 inclusive, so a phase lasts LOAD+1 cycles.
  localparam logic [N-1:0] HIGH_LOAD = N'(HIGH_CYC - 1);
  localparam logic [N-1:0] GAP_LOAD  = N'(GAP_CYC - 1);

  state_t       state, state_nxt;
  logic [N-1:0] cnt, cnt_nxt;
  logic [2:0]   pend_q;
  logic         want;
  logic         start;

  assign want = trig || (pend_q != 3'd0);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    unique case (state)
      IDLE: begin
        if (want) begin
          state_nxt = HIGH;
          cnt_nxt   = HIGH_LOAD;
          start     = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (want) begin
            state_nxt = HIGH;
            cnt_nxt   = HIGH_LOAD;
            start     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_level <= 1'b0;
      out_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_level <= (state_nxt == HIGH);
      out_start <= start;
    end
  end

`ifdef PULSE_QUEUE_EN
  logic pend_inc, pend_dec;

  // A start drains the queue first; the trig is only consumed when the queue
  // is empty, so trig plus a queue-fed start nets to no change.
  assign pend_dec = start && (pend_q != 3'd0);
  assign pend_inc = trig && !(start && (pend_q == 3'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 3'd0;
    end else if (pend_inc && !pend_dec) begin
      if (pend_q != PEND_MAX) pend_q <= pend_q + 3'd1;
    end else if (pend_dec && !pend_inc) begin
      pend_q <= pend_q - 3'd1;
    end
  end
`else
  assign pend_q = 3'd0;
`endif

  assign pending = pend_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: per-cycle vector tables on a short-period
// instance, plus a queue-saturation sequence on a long-HIGH instance.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       reset;
  logic       trig;
  logic       a_level, a_start, a_busy;
  logic [2:0] a_pending;
  logic       b_level, b_start, b_busy;
  logic [2:0] b_pending;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pulse_stretch #(.N(8), .HIGH_CYC(4), .GAP_CYC(3)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
    .out_level (a_level),
    .out_start (a_start),
    .busy      (a_busy),
    .pending   (a_pending)
  );

  pulse_stretch #(.N(4), .HIGH_CYC(10), .GAP_CYC(2)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
    .out_level (b_level),
    .out_start (b_start),
    .busy      (b_busy),
    .pending   (b_pending)
  );

  typedef struct {
    logic [31:0] trig_m;
    logic [31:0] rst_m;
    logic [31:0] level_m;
    logic [31:0] start_m;
    logic [31:0] busy_m;
    int          pc0, pc1, pc2;
    logic [2:0]  pv0, pv1, pv2;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] bit_at(input int i);
    logic [31:0] m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic hold_reset();
    reset = 1'b1;
    trig  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int starts;

    // Single trig: pulse 11-14, gap 15-17, idle at 18.
    vecs[0] = '{trig_m: bit_at(10), rst_m: '0, level_m: rng(11, 14),
                start_m: bit_at(11), busy_m: rng(11, 17),
                pc0: 11, pc1: 15, pc2: 18, pv0: 3'd0, pv1: 3'd0, pv2: 3'd0};
`ifdef PULSE_QUEUE_EN
    // Trigs at 10,12,13: two queued requests replayed at 18 and 25.
    vecs[1] = '{trig_m: bit_at(10) | bit_at(12) | bit_at(13), rst_m: '0,
                level_m: rng(11, 14) | rng(18, 21) | rng(25, 28),
                start_m: bit_at(11) | bit_at(18) | bit_at(25), busy_m: rng(11, 31),
                pc0: 14, pc1: 18, pc2: 25, pv0: 3'd2, pv1: 3'd1, pv2: 3'd0};
`else
    vecs[1] = '{trig_m: bit_at(10) | bit_at(12) | bit_at(13), rst_m: '0,
                level_m: rng(11, 14), start_m: bit_at(11), busy_m: rng(11, 17),
                pc0: 14, pc1: 18, pc2: 25, pv0: 3'd0, pv1: 3'd0, pv2: 3'd0};
`endif
    // Trig in the last gap cycle: back-to-back pulse at 18, no idle cycle.
    vecs[2] = '{trig_m: bit_at(10) | bit_at(17), rst_m: '0,
                level_m: rng(11, 14) | rng(18, 21), start_m: bit_at(11) | bit_at(18),
                busy_m: rng(11, 24),
                pc0: 17, pc1: 18, pc2: 22, pv0: 3'd0, pv1: 3'd0, pv2: 3'd0};
    // Reset at 13 mid-HIGH (trig at 13 ignored), fresh pulse from trig at 20.
    vecs[3] = '{trig_m: bit_at(10) | bit_at(12) | bit_at(13) | bit_at(20),
                rst_m: bit_at(13), level_m: rng(11, 13) | rng(21, 24),
                start_m: bit_at(11) | bit_at(21), busy_m: rng(11, 13) | rng(21, 27),
`ifdef PULSE_QUEUE_EN
                pc0: 13, pc1: 14, pc2: 21, pv0: 3'd1, pv1: 3'd0, pv2: 3'd0};
`else
                pc0: 13, pc1: 14, pc2: 21, pv0: 3'd0, pv1: 3'd0, pv2: 3'd0};
`endif

    for (int s = 0; s < 4; s++) begin
      hold_reset();
      for (int c = 0; c < 32; c++) begin
        reset = vecs[s].rst_m[c];
        trig  = vecs[s].trig_m[c];
        check($sformatf("vec%0d level/start/busy", s), c,
              {29'd0, a_level, a_start, a_busy},
              {29'd0, vecs[s].level_m[c], vecs[s].start_m[c], vecs[s].busy_m[c]});
        if (c == vecs[s].pc0) check($sformatf("vec%0d pending", s), c, 32'(a_pending), 32'(vecs[s].pv0));
        if (c == vecs[s].pc1) check($sformatf("vec%0d pending", s), c, 32'(a_pending), 32'(vecs[s].pv1));
        if (c == vecs[s].pc2) check($sformatf("vec%0d pending", s), c, 32'(a_pending), 32'(vecs[s].pv2));
        @(posedge clk);
        #1;
      end
    end

    // Saturation on the long-HIGH instance: trig 10..19, nine during HIGH 11-20.
    hold_reset();
    reset  = 1'b0;
    starts = 0;
    for (int c = 0; c < 140; c++) begin
      trig = (c >= 10) && (c <= 19);
      if (b_start) starts++;
      if (c == 15) check("sat level mid-pulse", c, 32'(b_level), 32'd1);
      if (c == 21) check("sat level in gap", c, 32'(b_level), 32'd0);
`ifdef PULSE_QUEUE_EN
      if (c == 20) check("sat pending at limit", c, 32'(b_pending), 32'd7);
      if (c == 23) check("sat pending after replay", c, 32'(b_pending), 32'd6);
`else
      if (c == 20) check("sat pending at limit", c, 32'(b_pending), 32'd0);
      if (c == 23) check("sat pending after replay", c, 32'(b_pending), 32'd0);
`endif
      @(posedge clk);
      #1;
    end
`ifdef PULSE_QUEUE_EN
    check("sat pulse count", 140, 32'(starts), 32'd8);
`else
    check("sat pulse count", 140, 32'(starts), 32'd1);
`endif
    check("sat busy at end", 140, 32'(b_busy), 32'd0);
    check("sat pending at end", 140, 32'(b_pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter N, default 22, meaning down-counter width in bits.
REQ-002 SHALL have parameter HIGH_CYC, default 4_000_000, meaning output high time in clk cycles (40 ms at 100 MHz); legal range 1..2^N.
REQ-003 SHALL have parameter GAP_CYC, default 4_000_000, meaning minimum output low time between pulses in clk cycles; legal range 1..2^N.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port trig  input  1  single-cycle event request, e.g. a debounced tick.
REQ-007 SHALL have port out_level  output  1  stretched pulse, registered.
REQ-008 SHALL have port out_start  output  1  one-cycle strobe coincident with the first high cycle of out_level, registered.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port pending  output  3  count of queued requests; reads 0 when PULSE_QUEUE_EN is undefined.

Function
REQ-011 SHALL implement FSM states IDLE, HIGH and GAP, plus an N-bit down-counter cnt.
REQ-012 SHALL, in IDLE with trig=1 or pending>0 at cycle t, enter HIGH at t+1 and load cnt=HIGH_CYC-1.
REQ-013 SHALL hold out_level=1 for exactly cycles t+1..t+HIGH_CYC, with out_start=1 only at t+1.
REQ-014 SHALL decrement cnt in HIGH; at cnt==0 it SHALL enter GAP and load cnt=GAP_CYC-1.
REQ-015 SHALL hold out_level=0 in GAP for exactly GAP_CYC cycles, decrementing cnt each cycle.
REQ-016 SHALL, in the last GAP cycle (cnt==0), go to HIGH if trig=1 or pending>0, else to IDLE; back-to-back pulses are therefore separated by exactly GAP_CYC low cycles.
REQ-017 SHALL take a start from pending (decrement) only when pending>0; otherwise a start consumes the same-cycle trig.
REQ-018 SHALL handle trig during HIGH, or during GAP with cnt!=0, per the Configuration section.
REQ-019 SHALL treat trig in the same cycle as a pending-consuming start as net zero change to pending.
REQ-020 SHALL saturate pending at 7; further triggers are dropped with no wrap.
REQ-021 SHALL treat counter arithmetic as N-bit unsigned with no wrap; cnt is reloaded before underflow.
REQ-022 SHALL drive busy=1 in HIGH and in GAP.

Reset
REQ-023 SHALL, while reset=1 on a clk edge, set state=IDLE, cnt=0, pending=0, out_level=0, out_start=0 and busy=0.
REQ-024 SHALL abort any pulse in progress on reset mid-operation; out_level=0 from the next cycle and queued requests are discarded.
REQ-025 SHALL ignore trig in a cycle where reset=1.

Configuration
REQ-026 SHALL, with macro PULSE_QUEUE_EN defined, increment pending on trig while in HIGH, or in GAP with cnt!=0, and replay queued requests per REQ-016/REQ-012.
REQ-027 SHALL, with PULSE_QUEUE_EN undefined, ignore trig in HIGH and in GAP except in the last GAP cycle; the pending register is not built and the port is tied to 0.

Structure
REQ-028 SHALL take the state encodings (IDLE=2'b00, HIGH=2'b01, GAP=2'b10) and the pending saturation limit (3'd7) from the shared package timer_pkg.
REQ-029 SHALL be a single module with no sub-module; the counter and FSM are inline.

Verification
REQ-030 SHALL cover: HIGH_CYC=4, GAP_CYC=3, trig at cycle 10 -> out_level high cycles 11-14, out_start at 11 only, busy high 11-17, IDLE at 18.
REQ-031 SHALL cover: queue enabled, trig at 10, 12, 13 -> pending reaches 2; pulses start at 11, 18 and 25; pending=0 after 25.
REQ-032 SHALL cover: queue disabled, same stimulus as REQ-031 -> single pulse 11-14 and pending stays 0.
REQ-033 SHALL cover: trig in the last GAP cycle (cycle 17) with pending=0 -> next pulse starts at 18 with no IDLE cycle.
REQ-034 SHALL cover: queue enabled, 9 trigs during HIGH -> pending saturates at 7 and exactly 8 pulses are emitted in total.
REQ-035 SHALL cover: reset asserted at cycle 13 mid-HIGH -> out_level=0, busy=0 and pending=0 from cycle 14; a trig at 20 produces a normal pulse at 21.
